// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: per-frame tick, game state machine, lives/score/ball speed for the breakout datapath.
// Define BRK_SCORE_BCD_EN for a 4-digit packed-BCD score; the default build keeps a saturating binary score.
module breakout_game_ctrl #(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned SPEED_INIT   = 5,
  parameter int unsigned SPEED_MAX    = 9,
  parameter int unsigned HITS_PER_UP  = 4,
  parameter int unsigned BRICK_PTS    = 10
) (
  input  logic        pix_clk,
  input  logic        reset_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        brick_hit,
  input  logic        ball_miss,
  input  logic        bricks_clear,
  output logic        frame_tick,
  output logic [2:0]  state,
  output logic        play_en,
  output logic        serve_load,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [3:0]  ball_speed
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_V_W = 10;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned SUM_W   = SCORE_W + 1;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned LIVES_W = 3;
`ifdef BRK_SCORE_BCD_EN
  localparam logic [SCORE_W-1:0] PTS_BCD = {8'h00, 4'(BRICK_PTS / 10), 4'(BRICK_PTS % 10)};
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    WIN   = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     serve_cnt, serve_cnt_d;
  logic [CNT_W-1:0]     hit_cnt, hit_cnt_d;
  logic                 btn_prev, btn_prev_d;
  logic [LIVES_W-1:0]   lives_d;
  logic [SCORE_W-1:0]   score_d;
  logic [SPEED_W-1:0]   speed_d;
  logic                 serve_load_d;
  logic                 frame_hit_c;
  logic                 btn_c;
  logic                 start_c;
  logic                 new_game_c;

  // Saturating score increment by BRICK_PTS in the configured number format.
  function automatic logic [SCORE_W-1:0] add_points(input logic [SCORE_W-1:0] s);
`ifdef BRK_SCORE_BCD_EN
    logic [SCORE_W-1:0] r;
    logic [4:0]         d;
    logic               c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = 5'(s[4*i +: 4]) + 5'(PTS_BCD[4*i +: 4]) + 5'(c);
      c = (d > 5'd9);
      if (c) d = d - 5'd10;
      r[4*i +: 4] = d[3:0];
    end
    return c ? 16'h9999 : r;
`else
    logic [SUM_W-1:0] t;
    t = SUM_W'(s) + SUM_W'(BRICK_PTS);
    return t[SCORE_W] ? 16'hFFFF : t[SCORE_W-1:0];
`endif
  endfunction

  assign frame_hit_c = (hcount == '0) && (hcount < CNT_V_W'(H_RES)) && (vcount == CNT_V_W'(V_RES));
  assign btn_c       = btn_left | btn_right;
  assign start_c     = frame_tick & btn_c & ~btn_prev;
  assign state       = state_q;
  assign play_en     = (state_q == PLAY);

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      frame_tick <= 1'b0;
      serve_load <= 1'b0;
      lives      <= '0;
      score      <= '0;
      ball_speed <= SPEED_W'(SPEED_INIT);
      serve_cnt  <= '0;
      hit_cnt    <= '0;
      btn_prev   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_tick <= frame_hit_c;
      serve_load <= serve_load_d;
      lives      <= lives_d;
      score      <= score_d;
      ball_speed <= speed_d;
      serve_cnt  <= serve_cnt_d;
      hit_cnt    <= hit_cnt_d;
      btn_prev   <= btn_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt;
    hit_cnt_d   = hit_cnt;
    btn_prev_d  = btn_prev;
    lives_d     = lives;
    score_d     = score;
    speed_d     = ball_speed;
    new_game_c  = 1'b0;

    if (frame_tick) btn_prev_d = btn_c;

    case (state_q)
      IDLE, WIN, OVER: new_game_c = start_c;
      SERVE: begin
        if (frame_tick) begin
          if (start_c || serve_cnt == CNT_W'(1)) state_d = PLAY;
          else serve_cnt_d = serve_cnt - CNT_W'(1);
        end
      end
      PLAY: begin
        // brick_hit always scores; clear beats miss for the state change
        if (brick_hit) begin
          score_d = add_points(score);
          if (hit_cnt == CNT_W'(HITS_PER_UP - 1)) begin
            hit_cnt_d = '0;
            if (ball_speed < SPEED_W'(SPEED_MAX)) speed_d = ball_speed + SPEED_W'(1);
          end else begin
            hit_cnt_d = hit_cnt + CNT_W'(1);
          end
        end
        if (bricks_clear) begin
          state_d = WIN;
        end else if (ball_miss) begin
          if (lives == LIVES_W'(1)) begin
            lives_d = '0;
            state_d = OVER;
          end else begin
            lives_d     = lives - LIVES_W'(1);
            serve_cnt_d = CNT_W'(SERVE_FRAMES);
            state_d     = SERVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_game_c) begin
      state_d     = SERVE;
      lives_d     = LIVES_W'(LIVES);
      score_d     = '0;
      speed_d     = SPEED_W'(SPEED_INIT);
      hit_cnt_d   = '0;
      serve_cnt_d = CNT_W'(SERVE_FRAMES);
    end

    serve_load_d = (state_d == SERVE) && (state_q != SERVE);
  end

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// tb_breakout_game_ctrl: directed scenarios plus randomized play against a
// hit-count based reference model of the breakout game controller.
module tb_breakout_game_ctrl;

  localparam int V_RES        = 480;
  localparam int LIVES        = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int SPEED_INIT   = 5;
  localparam int SPEED_MAX    = 9;
  localparam int HITS_PER_UP  = 4;
  localparam int BRICK_PTS    = 10;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_WIN = 3, S_OVER = 4;
`ifdef BRK_SCORE_BCD_EN
  localparam int          SCORE_CAP = 9999;
  localparam logic [15:0] SAT_VAL   = 16'h9999;
  localparam logic [15:0] SCORE80   = 16'h0080;
  localparam int          SAT_HITS  = 1010;
`else
  localparam int          SCORE_CAP = 65535;
  localparam logic [15:0] SAT_VAL   = 16'hFFFF;
  localparam logic [15:0] SCORE80   = 16'd80;
  localparam int          SAT_HITS  = 6600;
`endif

  logic        pix_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  hcount = 10'd5, vcount = 10'd5;
  logic        btn_left = 1'b0, btn_right = 1'b0;
  logic        brick_hit = 1'b0, ball_miss = 1'b0, bricks_clear = 1'b0;
  logic        frame_tick, play_en, serve_load;
  logic [2:0]  state, lives;
  logic [15:0] score;
  logic [3:0]  ball_speed;

  int errors = 0;
  int checks = 0;

  // Reference model: game position, lives and hits scored in the current game
  int m_state, m_lives, m_hits, m_serve;
  bit m_prev, m_ft, m_sl;

  breakout_game_ctrl dut (
    .pix_clk(pix_clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .btn_left(btn_left), .btn_right(btn_right), .brick_hit(brick_hit),
    .ball_miss(ball_miss), .bricks_clear(bricks_clear), .frame_tick(frame_tick),
    .state(state), .play_en(play_en), .serve_load(serve_load), .lives(lives),
    .score(score), .ball_speed(ball_speed)
  );

  always #5 pix_clk = ~pix_clk;

  function automatic logic [15:0] exp_score();
    longint v = longint'(m_hits) * BRICK_PTS;
    if (v > SCORE_CAP) v = SCORE_CAP;
`ifdef BRK_SCORE_BCD_EN
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
    return 16'(v);
`endif
  endfunction

  function automatic int exp_speed();
    int s = SPEED_INIT + m_hits / HITS_PER_UP;
    return (s > SPEED_MAX) ? SPEED_MAX : s;
  endfunction

  function automatic void model_reset();
    m_state = S_IDLE; m_lives = 0; m_hits = 0; m_serve = 0;
    m_prev = 0; m_ft = 0; m_sl = 0;
  endfunction

  function automatic void new_game();
    m_state = S_SERVE; m_lives = LIVES; m_hits = 0; m_serve = SERVE_FRAMES;
  endfunction

  // One clock of game rules, evaluated on the inputs present before the edge
  function automatic void model_step();
    bit tk    = m_ft;
    bit btn   = btn_left | btn_right;
    bit start = tk && btn && !m_prev;
    int prev  = m_state;
    if (tk) m_prev = btn;
    case (m_state)
      S_IDLE, S_WIN, S_OVER: if (start) new_game();
      S_SERVE: if (tk) begin
        if (start || m_serve == 1) m_state = S_PLAY;
        else m_serve--;
      end
      S_PLAY: begin
        if (brick_hit) m_hits++;
        if (bricks_clear) m_state = S_WIN;
        else if (ball_miss) begin
          m_lives--;
          if (m_lives == 0) m_state = S_OVER;
          else begin m_state = S_SERVE; m_serve = SERVE_FRAMES; end
        end
      end
      default: ;
    endcase
    m_sl = (m_state == S_SERVE) && (prev != S_SERVE);
    m_ft = (hcount == 10'd0) && (vcount == 10'(V_RES));
  endfunction

  task automatic step();
    model_step();
    @(posedge pix_clk);
    #1;
    hcount = 10'd5; vcount = 10'd5;
    brick_hit = 1'b0; ball_miss = 1'b0; bricks_clear = 1'b0;
  endtask

  task automatic frame();
    hcount = 10'd0; vcount = 10'(V_RES);
    step();
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    hcount = 10'd5; vcount = 10'd5;
    btn_left = 1'b0; btn_right = 1'b0;
    brick_hit = 1'b0; ball_miss = 1'b0; bricks_clear = 1'b0;
    repeat (2) @(posedge pix_clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  // Release then press a button across two frames to produce a start edge
  task automatic press();
    btn_left = 1'b0; frame();
    btn_left = 1'b1; frame();
    btn_left = 1'b0; frame();
  endtask

  task automatic test_reset();
    int ticks = 0;
    do_reset();
    checks++; if (state !== 3'd0 || lives !== 3'd0 || score !== 16'd0) begin
      errors++; $display("FAIL reset_regs: state=%0d lives=%0d score=%0h required 0/0/0", state, lives, score); end
    checks++; if (ball_speed !== 4'd5 || play_en !== 1'b0 || serve_load !== 1'b0 || frame_tick !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: speed=%0d play_en=%b serve_load=%b tick=%b required 5/0/0/0",
                          ball_speed, play_en, serve_load, frame_tick); end
    for (int f = 0; f < 2; f++) begin
      hcount = 10'd0; vcount = 10'd479; step();
      if (frame_tick) ticks++;
      hcount = 10'd1; vcount = 10'(V_RES); step();
      if (frame_tick) ticks++;
      hcount = 10'd0; vcount = 10'(V_RES); step();
      checks++; if (frame_tick !== 1'b1) begin
        errors++; $display("FAIL tick_at_480: got %b required 1", frame_tick); end
      step();
      if (frame_tick) ticks++;
    end
    checks++; if (ticks != 0) begin
      errors++; $display("FAIL tick_spurious: got %0d extra ticks required 0", ticks); end
    checks++; if (state !== 3'd0 || lives !== 3'd0 || ball_speed !== 4'd5) begin
      errors++; $display("FAIL idle_after_frames: state=%0d lives=%0d speed=%0d required 0/0/5", state, lives, ball_speed); end
  endtask

  task automatic test_serve();
    int n = 0;
    int loads = 0;
    btn_right = 1'b1;
    frame();
    checks++; if (state !== 3'd1 || serve_load !== 1'b1 || lives !== 3'd3) begin
      errors++; $display("FAIL serve_entry: state=%0d load=%b lives=%0d required 1/1/3", state, serve_load, lives); end
    step();
    checks++; if (serve_load !== 1'b0) begin
      errors++; $display("FAIL serve_load_width: got %b required 0", serve_load); end
    while (n < 200) begin
      frame();
      n++;
      if (serve_load) loads++;
      if (state == 3'd2) break;
    end
    checks++; if (n != SERVE_FRAMES || play_en !== 1'b1) begin
      errors++; $display("FAIL serve_frames: got %0d ticks play_en=%b required %0d/1", n, play_en, SERVE_FRAMES); end
    checks++; if (loads != 0) begin
      errors++; $display("FAIL serve_reload: got %0d extra serve_load required 0", loads); end
    btn_right = 1'b0;
    frame();
  endtask

  task automatic test_bricks();
    for (int i = 0; i < 8; i++) begin brick_hit = 1'b1; step(); end
    checks++; if (score !== SCORE80 || score !== exp_score()) begin
      errors++; $display("FAIL score_8_hits: got %0h required %0h", score, SCORE80); end
    checks++; if (ball_speed !== 4'd7) begin
      errors++; $display("FAIL speed_8_hits: got %0d required 7", ball_speed); end
    for (int i = 0; i < 24; i++) begin brick_hit = 1'b1; step(); end
    checks++; if (ball_speed !== 4'(SPEED_MAX) || ball_speed !== 4'(exp_speed())) begin
      errors++; $display("FAIL speed_saturate: got %0d required %0d", ball_speed, SPEED_MAX); end
  endtask

  task automatic test_miss();
    for (int k = 0; k < 3; k++) begin
      ball_miss = 1'b1; step();
      if (k < 2) begin
        checks++; if (lives !== 3'(2 - k) || state !== 3'd1 || serve_load !== 1'b1) begin
          errors++; $display("FAIL miss_%0d: lives=%0d state=%0d load=%b required %0d/1/1", k, lives, state, serve_load, 2 - k); end
        btn_left = 1'b1; frame();
        checks++; if (state !== 3'd2 || ball_speed !== 4'(SPEED_MAX)) begin
          errors++; $display("FAIL relaunch_%0d: state=%0d speed=%0d required 2/%0d", k, state, ball_speed, SPEED_MAX); end
        btn_left = 1'b0; frame();
      end
    end
    checks++; if (lives !== 3'd0 || state !== 3'd4 || play_en !== 1'b0) begin
      errors++; $display("FAIL game_over: lives=%0d state=%0d play_en=%b required 0/4/0", lives, state, play_en); end
    ball_miss = 1'b1; brick_hit = 1'b1; step();
    checks++; if (lives !== 3'd0 || score !== exp_score()) begin
      errors++; $display("FAIL events_outside_play: lives=%0d score=%0h required 0/%0h", lives, score, exp_score()); end
  endtask

  task automatic test_coincident();
    press();
    checks++; if (state !== 3'd1 || score !== 16'd0 || ball_speed !== 4'(SPEED_INIT)) begin
      errors++; $display("FAIL restart_over: state=%0d score=%0h speed=%0d required 1/0/%0d", state, score, ball_speed, SPEED_INIT); end
    press();
    checks++; if (state !== 3'd2) begin
      errors++; $display("FAIL launch_early: state=%0d required 2", state); end
    bricks_clear = 1'b1; ball_miss = 1'b1; brick_hit = 1'b1; step();
    checks++; if (state !== 3'd3 || lives !== 3'd3 || score !== 16'(BRICK_PTS)) begin
      errors++; $display("FAIL clear_priority: state=%0d lives=%0d score=%0h required 3/3/%0h", state, lives, score, BRICK_PTS); end
    btn_right = 1'b1; frame();
    checks++; if (state !== 3'd1 || score !== 16'd0 || serve_load !== 1'b1) begin
      errors++; $display("FAIL restart_win: state=%0d score=%0h load=%b required 1/0/1", state, score, serve_load); end
    btn_right = 1'b0; frame();
  endtask

  task automatic test_saturate();
    btn_left = 1'b1; frame(); btn_left = 1'b0; frame();
    for (int i = 0; i < SAT_HITS; i++) begin brick_hit = 1'b1; step(); end
    checks++; if (score !== SAT_VAL || score !== exp_score()) begin
      errors++; $display("FAIL score_saturate: got %0h required %0h", score, SAT_VAL); end
    checks++; if (state !== 3'd2) begin
      errors++; $display("FAIL still_play: state=%0d required 2", state); end
    reset_n = 1'b0;
    #2;
    checks++; if (state !== 3'd0 || lives !== 3'd0 || score !== 16'd0 || ball_speed !== 4'(SPEED_INIT)
                  || play_en !== 1'b0 || serve_load !== 1'b0 || frame_tick !== 1'b0) begin
      errors++; $display("FAIL async_reset: state=%0d lives=%0d score=%0h speed=%0d play_en=%b required 0/0/0/%0d/0",
                          state, lives, score, ball_speed, play_en, SPEED_INIT); end
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(5) == 0) begin hcount = 10'd0; vcount = 10'(V_RES); end
      if ($urandom_range(7) == 0) btn_left = ~btn_left;
      if ($urandom_range(9) == 0) btn_right = ~btn_right;
      brick_hit    = ($urandom_range(2) == 0);
      ball_miss    = ($urandom_range(60) == 0);
      bricks_clear = ($urandom_range(300) == 0);
      step();
      checks++;
      if (state !== 3'(m_state) || lives !== 3'(m_lives) || score !== exp_score()
          || ball_speed !== 4'(exp_speed()) || frame_tick !== m_ft || serve_load !== m_sl
          || play_en !== (m_state == S_PLAY)) begin
        errors++;
        if (bad < 5) $display("FAIL random_c%0d: state=%0d/%0d lives=%0d/%0d score=%0h/%0h speed=%0d/%0d tick=%b/%b load=%b/%b (got/required)",
                               c, state, m_state, lives, m_lives, score, exp_score(), ball_speed, exp_speed(),
                               frame_tick, m_ft, serve_load, m_sl);
        bad++;
      end
    end
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bricks();
    test_miss();
    test_coincident();
    test_saturate();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
